// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle: instruction-memory port, redirect request, IF/ID handshake and fault report.
// The master modport belongs to the sequencer; slave is the memory/pipeline side.
interface fetch_sequencer_if;
    logic [29:0] imem_addr;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [29:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [29:0] if_pc;
    logic        fault;
    logic [29:0] fault_pc;

    modport master (
        output imem_addr,
        input  imem_inst,
        input  redirect_valid,
        input  redirect_pc,
        input  id_ready,
        output if_valid,
        output if_inst,
        output if_pc,
        output fault,
        output fault_pc
    );

    modport slave (
        input  imem_addr,
        output imem_inst,
        output redirect_valid,
        output redirect_pc,
        input  id_ready,
        input  if_valid,
        input  if_inst,
        input  if_pc,
        input  fault,
        input  fault_pc
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: word-addressed PC, small fetch queue toward IF/ID,
// branch/jump redirect flush and halt-on-illegal-address fault handling.
module fetch_sequencer #(
    parameter logic [29:0] BASE  = 30'h00100000,
    parameter logic [29:0] LIMIT = 30'h00100100,
    parameter int unsigned DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    fetch_sequencer_if.master bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic {
        S_RUN,
        S_FAULT
    } state_e;

    state_e           state_q, state_d;
    logic [29:0]      pc_q, pc_d;
    logic             fault_q, fault_d;
    logic [29:0]      fault_pc_q, fault_pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [29:0]      slot_pc_q   [DEPTH];
    logic [31:0]      slot_inst_q [DEPTH];

    logic pc_legal;
    logic has_room;
    logic pop;
    logic push;
    logic take_fault;

    // A redirect suppresses both queue operations in its cycle; a full queue with a
    // pending pop still counts as having room so throughput stays one per cycle.
    always_comb begin
        pc_legal   = (pc_q >= BASE) && (pc_q <= LIMIT);
        pop        = (count_q != '0) && bus.id_ready && !bus.redirect_valid;
        has_room   = (count_q != FULL) || pop;
        push       = (state_q == S_RUN) && !bus.redirect_valid && pc_legal && has_room;
        take_fault = (state_q == S_RUN) && !bus.redirect_valid && !pc_legal && has_room;
    end

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through this block
        // leaves a variable unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        pc_d       = pc_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        if (bus.redirect_valid) begin
            state_d  = S_RUN;
            fault_d  = 1'b0;
            pc_d     = bus.redirect_pc;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            unique case (state_q)
                S_RUN: begin
                    if (take_fault) begin
                        state_d    = S_FAULT;
                        fault_d    = 1'b1;
                        fault_pc_d = pc_q;
                    end
                end
                S_FAULT: begin
                    fault_d = 1'b1;
                end
                default: state_d = S_RUN;
            endcase

            if (push) begin
                pc_d     = pc_q + 30'd1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_RUN;
            pc_q       <= BASE;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // NOTE: the queue slots are cleared on reset so the head outputs read as zero
    // rather than X before the first push; this is a flop array, not a RAM macro.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slot_pc_q[PTR_W'(i)]   <= '0;
                slot_inst_q[PTR_W'(i)] <= '0;
            end
        end else if (push) begin
            slot_pc_q[wr_ptr_q]   <= pc_q;
            slot_inst_q[wr_ptr_q] <= bus.imem_inst;
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.if_valid  = (count_q != '0);
    assign bus.if_inst   = slot_inst_q[rd_ptr_q];
    assign bus.if_pc     = slot_pc_q[rd_ptr_q];
    assign bus.fault     = fault_q;
    assign bus.fault_pc  = fault_pc_q;

    a_count_bound : assert property (@(posedge clk) disable iff (reset)
        count_q <= FULL);
    a_fault_no_push : assert property (@(posedge clk) disable iff (reset)
        (state_q == S_FAULT) |-> !push);
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: streaming, stall, redirect flush, range faults
// with drain, and mid-stream reset, all against hand-computed expected values.
module tb_fetch_sequencer;
    localparam logic [29:0] BASE  = 30'h00100000;
    localparam logic [29:0] LIMIT = 30'h00100100;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    fetch_sequencer_if bus ();

    fetch_sequencer #(
        .BASE  (BASE),
        .LIMIT (LIMIT),
        .DEPTH (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: word k of the legal window holds 32'h1000_0000 + k.
    function automatic logic [31:0] mem_word(input logic [29:0] addr);
        if (addr >= BASE && addr <= LIMIT)
            return 32'h1000_0000 + {2'b00, addr - BASE};
        return 32'hBAD0_0000;
    endfunction

    assign bus.imem_inst = mem_word(bus.imem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; outputs are sampled and inputs changed 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [29:0] target);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        tick();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
    endtask

    initial begin
        n_checks           = 0;
        n_fail             = 0;
        reset              = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.id_ready       = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_imem_addr", {2'b00, bus.imem_addr}, {2'b00, BASE});
        check("rst_if_valid",  {31'd0, bus.if_valid}, 32'd0);
        check("rst_if_inst",   bus.if_inst, 32'd0);
        check("rst_if_pc",     {2'b00, bus.if_pc}, 32'd0);
        check("rst_fault",     {31'd0, bus.fault}, 32'd0);
        check("rst_fault_pc",  {2'b00, bus.fault_pc}, 32'd0);

        // Streaming with id_ready=1: one instruction per cycle from BASE
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("stream_valid", {31'd0, bus.if_valid}, 32'd1);
            check("stream_pc",    {2'b00, bus.if_pc}, {2'b00, BASE + 30'(k)});
            check("stream_inst",  bus.if_inst, 32'h1000_0000 + k);
            check("stream_fault", {31'd0, bus.fault}, 32'd0);
        end

        // Stall: id_ready low from reset fills the queue after two pushes
        reset        = 1'b1;
        bus.id_ready = 1'b0;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("stall_imem_addr", {2'b00, bus.imem_addr}, {2'b00, BASE + 30'd2});
        check("stall_if_pc",     {2'b00, bus.if_pc}, {2'b00, BASE});
        check("stall_if_valid",  {31'd0, bus.if_valid}, 32'd1);
        bus.id_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("resume_pc",   {2'b00, bus.if_pc}, {2'b00, BASE + 30'(k)});
            check("resume_inst", bus.if_inst, 32'h1000_0000 + k);
        end

        // Redirect on a full queue in the same cycle as id_ready=1
        bus.id_ready = 1'b0;
        tick();
        bus.id_ready = 1'b1;
        redirect_to(BASE + 30'h40);
        check("redir_flush_valid", {31'd0, bus.if_valid}, 32'd0);
        check("redir_imem_addr",   {2'b00, bus.imem_addr}, {2'b00, BASE + 30'h40});
        tick();
        check("redir_head_valid", {31'd0, bus.if_valid}, 32'd1);
        check("redir_head_pc",    {2'b00, bus.if_pc}, {2'b00, BASE + 30'h40});
        check("redir_head_inst",  bus.if_inst, 32'h1000_0040);

        // Run off the top of the window: FF and 100 delivered, then fault at 101
        redirect_to(BASE + 30'hFF);
        tick();
        check("top_pc_ff",   {2'b00, bus.if_pc}, {2'b00, BASE + 30'hFF});
        check("top_inst_ff", bus.if_inst, 32'h1000_00FF);
        tick();
        check("top_pc_100",   {2'b00, bus.if_pc}, {2'b00, LIMIT});
        check("top_inst_100", bus.if_inst, 32'h1000_0100);
        check("top_no_fault", {31'd0, bus.fault}, 32'd0);
        tick();
        check("top_fault",     {31'd0, bus.fault}, 32'd1);
        check("top_fault_pc",  {2'b00, bus.fault_pc}, {2'b00, LIMIT + 30'd1});
        check("top_drained",   {31'd0, bus.if_valid}, 32'd0);
        tick();
        check("top_pc_holds",  {2'b00, bus.imem_addr}, {2'b00, LIMIT + 30'd1});
        check("top_fault_sticks", {31'd0, bus.fault}, 32'd1);
        redirect_to(BASE);
        check("clear_fault",     {31'd0, bus.fault}, 32'd0);
        check("clear_imem_addr", {2'b00, bus.imem_addr}, {2'b00, BASE});
        tick();
        check("clear_head_pc",   {2'b00, bus.if_pc}, {2'b00, BASE});

        // Fault with a full queue: entries still drain after the fault is raised
        bus.id_ready = 1'b0;
        redirect_to(BASE + 30'hFF);
        tick();
        tick();
        tick();
        check("full_top_no_fault", {31'd0, bus.fault}, 32'd0);
        bus.id_ready = 1'b1;
        tick();
        check("drain_fault",    {31'd0, bus.fault}, 32'd1);
        check("drain_valid",    {31'd0, bus.if_valid}, 32'd1);
        check("drain_head_pc",  {2'b00, bus.if_pc}, {2'b00, LIMIT});
        tick();
        check("drain_empty",    {31'd0, bus.if_valid}, 32'd0);

        // Redirect below the window faults on the following cycle with no push
        redirect_to(30'h000FFFFF);
        check("low_no_fault_yet", {31'd0, bus.fault}, 32'd0);
        check("low_imem_addr",    {2'b00, bus.imem_addr}, 32'h000FFFFF);
        tick();
        check("low_fault",    {31'd0, bus.fault}, 32'd1);
        check("low_fault_pc", {2'b00, bus.fault_pc}, 32'h000FFFFF);
        check("low_no_push",  {31'd0, bus.if_valid}, 32'd0);

        // Reset mid-stream with one queued entry, then restart from BASE
        redirect_to(BASE);
        tick();
        tick();
        check("mid_head_pc", {2'b00, bus.if_pc}, {2'b00, BASE + 30'd1});
        reset = 1'b1;
        tick();
        check("mid_rst_valid",     {31'd0, bus.if_valid}, 32'd0);
        check("mid_rst_imem_addr", {2'b00, bus.imem_addr}, {2'b00, BASE});
        check("mid_rst_fault",     {31'd0, bus.fault}, 32'd0);
        reset = 1'b0;
        tick();
        check("restart_pc0", {2'b00, bus.if_pc}, {2'b00, BASE});
        tick();
        check("restart_pc1", {2'b00, bus.if_pc}, {2'b00, BASE + 30'd1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
